// File: rtl/serializador_piso_pkg.sv
// Shared definitions for the PISO serializer: state encoding, default width
// and the bit-counter width helper.
package serializador_piso_pkg;

  localparam int LARGURA_PADRAO = 8;

  typedef logic [0:0] estado_t;

  localparam estado_t OCIOSO     = 1'b0;
  localparam estado_t DESLOCANDO = 1'b1;

  // Counter must hold LARGURA-1; a 2-bit word still needs one counter bit.
  function automatic int largura_contador(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serializador_piso_if.sv
// Handshake and data bundle between a word source and the PISO serializer.
interface serializador_piso_if #(
  parameter int LARGURA = 8
);
  logic               load;
  logic [LARGURA-1:0] dado;
  logic               hab;
  logic               pronto;
  logic               ocupado;
  logic               sout;
  logic               fim;

  modport master (
    output load, dado, hab,
    input  pronto, ocupado, sout, fim
  );

  modport slave (
    input  load, dado, hab,
    output pronto, ocupado, sout, fim
  );
endinterface

// File: rtl/serializador_piso_registrador_deslocamento.sv
// Shift register plus down-counting bit counter for the PISO serializer.
module registrador_deslocamento
  import serializador_piso_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter bit MSB_PRIMEIRO = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               carga,
  input  logic               desloca,
  input  logic [LARGURA-1:0] dado,
  output logic               bit_saida,
  output logic               cnt_zero
);

  localparam int CW = largura_contador(LARGURA);

  logic [LARGURA-1:0] registro;
  logic [CW-1:0]      contador;

  // Load takes priority; shifting stops at the last bit so the counter never wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      registro <= '1;
      contador <= '0;
    end else if (carga) begin
      registro <= dado;
      contador <= CW'(LARGURA - 1);
    end else if (desloca && (contador != '0)) begin
      if (MSB_PRIMEIRO)
        registro <= {registro[LARGURA-2:0], 1'b1};
      else
        registro <= {1'b1, registro[LARGURA-1:1]};
      contador <= contador - CW'(1);
    end
  end

  assign bit_saida = MSB_PRIMEIRO ? registro[LARGURA-1] : registro[0];
  assign cnt_zero  = (contador == '0);

endmodule

// File: rtl/serializador_piso.sv
// Parallel-in serial-out serializer: FSM, handshake and end-of-word logic.
//
//   state      | meaning
//   -----------+------------------------------------------------
//   OCIOSO     | line idle high, ready for a new word
//   DESLOCANDO | word in flight, one bit per hab tick
module serializador_piso
  import serializador_piso_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter bit MSB_PRIMEIRO = 1'b1
) (
  input logic                clk,
  input logic                rstn,
  serializador_piso_if.slave bus
);

  estado_t estado;
  logic    cnt_zero;
  logic    bit_saida;
  logic    fim_int;
  logic    pronto_int;
  logic    aceita;
  logic    desloca;

  assign fim_int    = (estado == DESLOCANDO) && cnt_zero;
  // Ready again on the final bit's tick so the next word follows with no gap.
  assign pronto_int = (estado == OCIOSO) || (fim_int && bus.hab);
  assign aceita     = bus.load && pronto_int;
  assign desloca    = (estado == DESLOCANDO) && bus.hab;

  // State moves to DESLOCANDO on an accepted load, back to OCIOSO when the last bit ends.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      estado <= OCIOSO;
    else if (aceita)
      estado <= DESLOCANDO;
    else if (fim_int && bus.hab)
      estado <= OCIOSO;
  end

  registrador_deslocamento #(
    .LARGURA      (LARGURA),
    .MSB_PRIMEIRO (MSB_PRIMEIRO)
  ) u_reg (
    .clk       (clk),
    .rstn      (rstn),
    .carga     (aceita),
    .desloca   (desloca),
    .dado      (bus.dado),
    .bit_saida (bit_saida),
    .cnt_zero  (cnt_zero)
  );

  assign bus.pronto  = pronto_int;
  assign bus.fim     = fim_int;
  assign bus.ocupado = (estado == DESLOCANDO);
  assign bus.sout    = (estado == DESLOCANDO) ? bit_saida : 1'b1;

endmodule

// File: doc/serializador_piso.md
SERIALIZADOR_PISO -- requirements
Module: serializador_piso

Interface
REQ-001 Parameters SHALL be:
- LARGURA, default 8, word width in bits (>=2).
- MSB_PRIMEIRO, default 1; 1 shifts MSB first, 0 shifts LSB first.

REQ-002 Ports SHALL be:
- Clk  input  1  single clock, all state updates on rising edge.
- Rstn  input  1  asynchronous, active-low reset.
- Load  input  1  request to load Dado for transmission.
- Dado  input  LARGURA  parallel word, sampled only when a load is accepted.
- Hab  input  1  bit-advance enable (baud tick).
- Pronto  output  1  block can accept a load this cycle.
- Ocupado  output  1  a word is being shifted out.
- Sout  output  1  serial data.
- Fim  output  1  high while the final bit of a word is on Sout.

REQ-003 The block SHALL have one clock, Clk, and one asynchronous active-low reset, Rstn; no other clock or reset SHALL exist.

Function
REQ-004 FSM SHALL have two states: OCIOSO and DESLOCANDO.
REQ-005 Load SHALL be accepted on a rising edge where Load=1 and Pronto=1; Load while Pronto=0 SHALL be ignored, with no state change.
REQ-006 Pronto SHALL be 1 in OCIOSO, and 1 in DESLOCANDO only when Fim=1 and Hab=1 (combinational), which permits back-to-back words.
REQ-007 On acceptance:
- Dado is captured into the shift register.
- The bit counter is set to LARGURA-1.
- The state becomes DESLOCANDO.
- The first bit (Dado[LARGURA-1] if MSB_PRIMEIRO=1, else Dado[0]) appears on Sout in the next cycle.
REQ-008 In DESLOCANDO, each edge with Hab=1 and counter>0 SHALL shift one bit and decrement the counter; with Hab=0, Sout and the counter SHALL hold.
REQ-009 Fim SHALL equal 1 when in DESLOCANDO and counter=0.
REQ-010 An edge with Fim=1 and Hab=1 SHALL end the word:
- With an accepted Load, the new word loads per REQ-007.
- Otherwise the state returns to OCIOSO.
REQ-011 Ocupado SHALL be 1 exactly in DESLOCANDO.
REQ-012 In OCIOSO, Sout SHALL be 1 (line idle high).
REQ-013 Each word SHALL occupy Sout for exactly LARGURA Hab-qualified bit periods, in order, with no repeated or dropped bit.
REQ-014 Counter width SHALL be ceil(log2(LARGURA)); the counter SHALL never wrap below 0.
REQ-015 Changes on Dado after acceptance SHALL NOT affect the word in flight.

Reset
REQ-016 Rstn=0 SHALL immediately, without waiting for Clk, force:
- state OCIOSO, counter 0, shift register all ones;
- Sout=1, Ocupado=0, Fim=0, Pronto=1.
REQ-017 Reset asserted mid-word SHALL abort the word; the remaining bits SHALL NOT be sent after release.
REQ-018 After Rstn rises, the first accepted Load SHALL behave per REQ-007.

Structure
REQ-019 A shared package SHALL hold the OCIOSO/DESLOCANDO state encoding, the LARGURA default and the counter-width function.
REQ-020 The shift register plus its bit counter SHALL be one sub-module, registrador_deslocamento, with load, shift and reset inputs; serializador_piso SHALL contain the FSM and the Pronto/Fim logic.

Verification
REQ-021 Reset, then Load=1 with Dado=8'hA5 and Hab=1 every cycle; MSB_PRIMEIRO=1 -> Sout sequence 1,0,1,0,0,1,0,1, Fim high on the 8th bit only, then Sout=1 and Ocupado=0.
REQ-022 Same stimulus with MSB_PRIMEIRO=0 and Dado=8'h01 -> Sout 1,0,0,0,0,0,0,0.
REQ-023 Hab pulsed every 3rd cycle with Dado=8'hF0 -> each bit held for exactly 3 cycles; total 24 cycles in DESLOCANDO.
REQ-024 Load=1 held, Dado 8'h3C then 8'hC3 -> 16 contiguous bits with no idle gap; Pronto high only on the final-bit cycles; a Load pulse during bit 4 is ignored.
REQ-025 Rstn=0 asserted between clock edges during bit 5 of 8'hFF -> Sout=1 and Ocupado=0 immediately; after release, no residual bits are sent.
